fifo_stream_reader: RTL

//  Read-side master for the line-buffer sync FIFOs in the 5x5 conv datapath.
//  - Drains a FIFO that has a read-enable/empty interface and same-cycle read data.
//  - Re-issues the words as a valid/ready stream to the window generator.
//  - A 2-entry holding buffer gives 1 word/cycle with no comb path from i_ready to o_fifo_r_en.

---
 rtl/cnn_stream_pkg.sv | 22 ++
 rtl/skid_buf2.sv | 74 +++++++
 rtl/fifo_stream_reader.sv | 107 ++++++++++
 3 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared constants and types for the conv-datapath stream blocks.
package cnn_stream_pkg;

  localparam int unsigned DataWDef = 8;
  localparam int unsigned ImgWDef  = 28;
  localparam int unsigned ImgHDef  = 28;

  // Counter width able to hold 0..n-1; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ColWDef = cnt_width(ImgWDef);
  localparam int unsigned RowWDef = cnt_width(ImgHDef);

  // Holding-buffer occupancy, 0..2.
  typedef logic [1:0] occ_t;
  localparam occ_t OccEmpty = 2'd0;
  localparam occ_t OccOne   = 2'd1;
  localparam occ_t OccFull  = 2'd2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready holding buffer. head_q is always the oldest word and
// drives data_o directly, so the output is fully registered.
module skid_buf2
  import cnn_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output occ_t              occ_o
);

  occ_t              occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              do_push, do_pop;

  // Next-state: a push into an empty buffer or a push+pop at occ 1 lands in head.
  always_comb begin
    occ_d   = occ_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_push = push_i & (occ_q != OccFull);
    do_pop  = pop_i & (occ_q != OccEmpty);
    unique case ({do_push, do_pop})
      2'b10: begin
        if (occ_q == OccEmpty) head_d = data_i;
        else                   tail_d = data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at occ 1: the lone entry leaves as the new one arrives.
        head_d = data_i;
      end
      default: ;
    endcase
    if (clr_i) begin
      occ_d  = OccEmpty;
      head_d = '0;
      tail_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q  <= OccEmpty;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    valid_o = (occ_q != OccEmpty);
    data_o  = head_q;
    occ_o   = occ_q;
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the line-buffer FIFOs: drains a read-enable/empty FIFO
// into a valid/ready stream through a 2-entry buffer, so o_fifo_r_en depends
// only on registered occupancy and never on i_ready.
// Optional framing tags (sof/eol/eof) are built when FIFO_RD_FRAME_TAG_EN is
// defined; otherwise the flags are tied low.
module fifo_stream_reader
  import cnn_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned IMG_W  = ImgWDef,
  parameter int unsigned IMG_H  = ImgHDef
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_r_en,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof
);

  if (IMG_W < 1 || IMG_H < 1) begin : g_bad_dims
    $error("fifo_stream_reader: IMG_W and IMG_H must be at least 1");
  end

  occ_t occ;
  logic pop;

  // FIFO read request; reset gating keeps the enable low while held in reset.
  always_comb begin
    o_fifo_r_en = i_rst_n & ~i_fifo_empty & (occ != OccFull) & ~i_clr;
    pop         = o_valid & i_ready;
  end

  skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr_i   (i_clr),
    .push_i  (o_fifo_r_en),
    .data_i  (i_fifo_data),
    .pop_i   (pop),
    .valid_o (o_valid),
    .data_o  (o_data),
    .occ_o   (occ)
  );

`ifdef FIFO_RD_FRAME_TAG_EN
  localparam int unsigned ColW = cnt_width(IMG_W);
  localparam int unsigned RowW = cnt_width(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // Position of the head word; advances when the head is accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pop) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (i_clr) begin
      col_d = '0;
      row_d = '0;
    end
  end

  // Framing counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Flags describe the head word and are masked when no word is presented.
  always_comb begin
    o_sof = o_valid & (col_q == '0) & (row_q == '0);
    o_eol = o_valid & (col_q == ColLast);
    o_eof = o_valid & (col_q == ColLast) & (row_q == RowLast);
  end
`else
  // Framing not built.
  always_comb begin
    o_sof = 1'b0;
    o_eol = 1'b0;
    o_eof = 1'b0;
  end
`endif

endmodule
